barrel_shifter_32: RTL and testbench
====================================

Name: barrel_shifter_32

Overview:
- 32-bit barrel shifter with a registered output, used as the shift unit of the datapath/ALU.
- Shifts a data word left (logical, zero fill) or right (arithmetic, sign fill) by 0..31 positions.
- Combinational log-shifter core followed by one output register.
- Single clock domain with a synchronous, active-high reset.

Parameters:
- WIDTH, 32, data width in bits; must be a power of two, at least 2.
- AMT_W, log2(WIDTH) = 5, width of the shift-amount field.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies sh_dir, sh_amt and d_in in the current cycle.
- sh_dir  input  1  shift direction: 0 = shift left logical, 1 = shift right arithmetic.
- sh_amt  input  AMT_W  shift distance, 0..WIDTH-1.
- d_in  input  WIDTH  operand.
- d_out  output  WIDTH  registered shift result.
- out_valid  output  1  high for one cycle when d_out holds a new result.

Behaviour:
- Reset: one clock and one reset, synchronous active-high. While rst is high at a rising clk edge, d_out <= 0 and out_valid <= 0.
- rst has priority over in_valid in the same cycle; a transaction presented during reset is dropped.
- Latency: exactly 1 cycle. Inputs sampled at edge N with in_valid=1 produce d_out and out_valid=1 after edge N.
- Throughput: one operation per cycle, back-to-back, with no stalls.
- No hold: in_valid=0 at an edge gives out_valid <= 0, and d_out holds its previous value.
- Left shift (sh_dir=0): d_out = d_in << sh_amt.
  - Vacated LSBs are filled with 0.
  - Bits shifted past the MSB are discarded.
- Right shift (sh_dir=1): d_out = d_in >>> sh_amt.
  - Vacated MSBs are filled with d_in[WIDTH-1].
  - Bits shifted past the LSB are discarded.
- sh_amt=0 passes d_in through unchanged in both directions.
- sh_amt=WIDTH-1 gives the following results:
  - Left: d_in[0] lands in the MSB; all other bits are 0.
  - Right: every bit equals the sign bit.
- No rotate mode and no logical-right mode. sh_amt is never interpreted modulo anything beyond its field width.
- Core structure: AMT_W cascaded stages. Stage k shifts by 2^k when sh_amt[k]=1, otherwise it passes the word through. Direction and fill apply identically in every stage.
- Fill bit for right shifts is taken from the original d_in MSB, not recomputed per stage. These are equivalent for arithmetic shifts, but the original MSB is mandated.
- No combinational path from inputs to outputs. Both outputs come straight from flops.
- No X propagation: outputs are fully defined after the first reset.

Decomposition:
- Shared package shifter_pkg holds the following:
  - WIDTH and AMT_W defaults.
  - Direction encoding constants SH_LEFT = 1'b0 and SH_RIGHT = 1'b1.
- One natural sub-module: barrel_shift_core.
  - Purely combinational; parameterised by WIDTH.
  - Inputs sh_dir, sh_amt and d_in; output the shifted word.
  - Built from a generate loop over the AMT_W stages.
- The top level adds the input qualification, the output register and the reset.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and d_in=32'hFFFF_FFFF. Required: d_out=0 and out_valid=0 throughout. Release rst; the first result appears 1 cycle after the first valid input.
- Negative right-shift sweep: sh_dir=1, d_in=32'h8000_0000, sh_amt=0..31, one per cycle back-to-back. Required: d_out is the top (amt+1) bits set, one cycle later.
  - amt=0 gives 32'h8000_0000.
  - amt=1 gives 32'hC000_0000.
  - amt=31 gives 32'hFFFF_FFFF.
- Positive right-shift sweep: sh_dir=1, d_in=32'h4000_0000, sh_amt=0..31. Required: d_out = 32'h4000_0000 >> amt with zero fill.
  - amt=30 gives 32'h0000_0001.
  - amt=31 gives 32'h0000_0000.
- Left-shift sweep: sh_dir=0, d_in=32'h0000_0001, sh_amt=0..31. Required: d_out = 1 << amt.
  - amt=31 gives 32'h8000_0000.
  - Also: d_in=32'hFFFF_FFFF with amt=4 gives 32'hFFFF_FFF0 (zero fill).
- Valid gaps and direction toggling: alternate sh_dir each cycle with d_in=32'hF000_000F, amt=4, then drop in_valid for 2 cycles. Required:
  - Left gives 32'h0000_00F0.
  - Right gives 32'hFF00_0000.
  - During the gap, out_valid=0 and d_out holds the last result.
- Random check: 1000 random (sh_dir, sh_amt, d_in) triples with random in_valid and occasional mid-stream rst. Required: d_out matches a reference model (<< or signed >>>) one cycle later, and the state is cleared on every rst edge.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared constants for the 32-bit barrel shifter: data/amount widths and
// the direction encoding used by the core and the top level.
package shifter_pkg;
  localparam int WIDTH = 32;
  localparam int AMT_W = $clog2(WIDTH);

  localparam logic SH_LEFT  = 1'b0;
  localparam logic SH_RIGHT = 1'b1;
endpackage

// File: rtl/barrel_shifter_32_if.sv
// Operand/result bundle for the barrel shifter. Valid-only protocol: the
// producer asserts in_valid for one cycle per operation and the shifter never
// stalls; out_valid pulses for exactly one cycle per result.
interface barrel_shifter_32_if
  import shifter_pkg::*;
#(
  parameter int W = WIDTH,
  parameter int A = AMT_W
);
  logic         in_valid;
  logic         sh_dir;
  logic [A-1:0] sh_amt;
  logic [W-1:0] d_in;
  logic [W-1:0] d_out;
  logic         out_valid;

  modport master (
    output in_valid, sh_dir, sh_amt, d_in,
    input  d_out, out_valid
  );

  modport slave (
    input  in_valid, sh_dir, sh_amt, d_in,
    output d_out, out_valid
  );
endinterface

// File: rtl/barrel_shift_core.sv
// Combinational log shifter: AMT_W cascaded stages, stage k moves the word by
// 2^k. Left shifts zero-fill; right shifts fill with the operand's original MSB.
module barrel_shift_core
  import shifter_pkg::*;
#(
  parameter int WIDTH_P = WIDTH,
  parameter int AMT_P   = $clog2(WIDTH_P)
) (
  input  logic               sh_dir,
  input  logic [AMT_P-1:0]   sh_amt,
  input  logic [WIDTH_P-1:0] d_in,
  output logic [WIDTH_P-1:0] d_out
);
  logic               fill;
  logic [WIDTH_P-1:0] stage [AMT_P+1];

  // Sign fill comes from the untouched operand, not from any stage output.
  assign fill     = d_in[WIDTH_P-1];
  assign stage[0] = d_in;

  for (genvar k = 0; k < AMT_P; k++) begin : g_stage
    localparam int SH = 1 << k;
    logic [WIDTH_P-1:0] moved;

    assign moved = (sh_dir == SH_RIGHT)
                 ? {{SH{fill}}, stage[k][WIDTH_P-1:SH]}
                 : {stage[k][WIDTH_P-1-SH:0], {SH{1'b0}}};

    assign stage[k+1] = sh_amt[k] ? moved : stage[k];
  end

  assign d_out = stage[AMT_P];
endmodule

// File: rtl/barrel_shifter_32.sv
// Registered 32-bit shifter: qualifies the operand with in_valid, shifts it in
// the combinational core and captures the result in one output register.
module barrel_shifter_32
  import shifter_pkg::*;
(
  input logic clk,
  input logic rst,
  barrel_shifter_32_if.slave bus
);
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] d_q;
  logic             v_q;

  barrel_shift_core #(.WIDTH_P(WIDTH)) u_core (
    .sh_dir (bus.sh_dir),
    .sh_amt (bus.sh_amt),
    .d_in   (bus.d_in),
    .d_out  (shifted)
  );

  // Result register holds its value across idle cycles; only out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= '0;
      v_q <= 1'b0;
    end else begin
      v_q <= bus.in_valid;
      if (bus.in_valid) begin
        d_q <= shifted;
      end
    end
  end

  assign bus.d_out     = d_q;
  assign bus.out_valid = v_q;
endmodule

// File: tb/tb_barrel_shifter_32.sv
// Bench for barrel_shifter_32: directed sweeps with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_barrel_shifter_32;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic started;

  barrel_shifter_32_if bus ();

  barrel_shifter_32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_shift(input logic dir, input logic [4:0] amt,
                                            input logic [31:0] d);
    logic signed [31:0] s;
    s = d;
    if (dir) return 32'(s >>> amt);
    else     return d << amt;
  endfunction

  logic        m_valid;
  logic [31:0] m_dout;

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_dout  <= '0;
      started <= 1'b1;
    end else begin
      m_valid <= bus.in_valid;
      if (bus.in_valid) m_dout <= ref_shift(bus.sh_dir, bus.sh_amt, bus.d_in);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (started === 1'b1) begin
      check("out_valid_model", 32'(bus.out_valid), 32'(m_valid));
      check("d_out_model", bus.d_out, m_dout);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic v, input logic dir,
                      input logic [4:0] amt, input logic [31:0] d);
    rst          = r;
    bus.in_valid = v;
    bus.sh_dir   = dir;
    bus.sh_amt   = amt;
    bus.d_in     = d;
    @(negedge clk);
  endtask

  logic [31:0] exp_v;

  initial begin
    total   = 0;
    bad     = 0;
    started = 1'b0;
    rst = 1'b1; bus.in_valid = 1'b0; bus.sh_dir = 1'b0; bus.sh_amt = '0; bus.d_in = '0;
    @(negedge clk);

    // Reset dominates a valid transaction.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF);
      check("rst_d_out", bus.d_out, 32'h0);
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    end

    // Negative right sweep: top amt+1 bits set.
    for (int a = 0; a < 32; a++) begin
      step(1'b0, 1'b1, 1'b1, 5'(a), 32'h8000_0000);
      exp_v = ~(32'hFFFF_FFFF >> (a + 1));
      check("neg_right_sweep", bus.d_out, exp_v);
      check("neg_right_valid", 32'(bus.out_valid), 32'h1);
      if (a == 0)  check("neg_right_0", bus.d_out, 32'h8000_0000);
      if (a == 1)  check("neg_right_1", bus.d_out, 32'hC000_0000);
      if (a == 31) check("neg_right_31", bus.d_out, 32'hFFFF_FFFF);
    end

    // Positive right sweep: zero fill.
    for (int a = 0; a < 32; a++) begin
      step(1'b0, 1'b1, 1'b1, 5'(a), 32'h4000_0000);
      if (a == 30) check("pos_right_30", bus.d_out, 32'h0000_0001);
      if (a == 31) check("pos_right_31", bus.d_out, 32'h0000_0000);
    end

    // Left sweep.
    for (int a = 0; a < 32; a++) begin
      step(1'b0, 1'b1, 1'b0, 5'(a), 32'h0000_0001);
      exp_v = 32'h1 << a;
      check("left_sweep", bus.d_out, exp_v);
      if (a == 31) check("left_31", bus.d_out, 32'h8000_0000);
    end
    step(1'b0, 1'b1, 1'b0, 5'd4, 32'hFFFF_FFFF);
    check("left_ones_4", bus.d_out, 32'hFFFF_FFF0);

    // Direction toggling then a two-cycle gap.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'(i % 2), 5'd4, 32'hF000_000F);
      check("toggle", bus.d_out, (i % 2 == 1) ? 32'hFF00_0000 : 32'h0000_00F0);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 5'd7, 32'h1234_5678);
      check("gap_out_valid", 32'(bus.out_valid), 32'h0);
      check("gap_hold", bus.d_out, 32'hFF00_0000);
    end

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
      if (rst) begin
        check("rand_rst_d_out", bus.d_out, 32'h0);
        check("rand_rst_valid", 32'(bus.out_valid), 32'h0);
      end
    end

    step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
